// File: rtl/dag_host_seq_ctrl_if.sv
// rtl/dag_host_seq_ctrl_if.sv - host job port, word streams and processor init port of the DAG sequencer
// master: sequencer view; slave: host/processor view.
interface dag_host_seq_ctrl_if #(
  parameter int INSTR_L      = 32,
  parameter int WORD_L       = 32,
  parameter int INSTR_ADDR_L = 10,
  parameter int DATA_ADDR_L  = 12
);
  // host job descriptor and status
  logic                      start;
  logic [INSTR_ADDR_L:0]     cfg_n_instr;
  logic [DATA_ADDR_L:0]      cfg_n_data;
  logic [DATA_ADDR_L-1:0]    cfg_out_base;
  logic [DATA_ADDR_L:0]      cfg_n_out;
  logic                      cfg_ping;
  logic                      busy;
  logic                      done;
  logic                      err_timeout;
  // input word stream
  logic                      s_valid;
  logic                      s_ready;
  logic [INSTR_L-1:0]        s_data;
  // result stream
  logic                      m_valid;
  logic                      m_ready;
  logic [WORD_L-1:0]         m_data;
  // processor init/exec port
  logic                      enable_execution;
  logic [INSTR_L-1:0]        init_instr;
  logic [INSTR_ADDR_L-1:0]   init_instr_addr;
  logic                      init_instr_we;
  logic                      io_ping_wr;
  logic [INSTR_ADDR_L-1:0]   current_instr_rd_addr;
  logic [WORD_L-1:0]         init_data_in;
  logic [WORD_L-1:0]         init_data_out;
  logic [DATA_ADDR_L-1:0]    init_data_addr;
  logic                      init_data_we;
  logic                      init_data_re;

  modport master (
    input  start, cfg_n_instr, cfg_n_data, cfg_out_base, cfg_n_out, cfg_ping,
    input  s_valid, s_data, m_ready, current_instr_rd_addr, init_data_out,
    output busy, done, err_timeout, s_ready, m_valid, m_data,
    output enable_execution, init_instr, init_instr_addr, init_instr_we, io_ping_wr,
    output init_data_in, init_data_addr, init_data_we, init_data_re
  );

  modport slave (
    output start, cfg_n_instr, cfg_n_data, cfg_out_base, cfg_n_out, cfg_ping,
    output s_valid, s_data, m_ready, current_instr_rd_addr, init_data_out,
    input  busy, done, err_timeout, s_ready, m_valid, m_data,
    input  enable_execution, init_instr, init_instr_addr, init_instr_we, io_ping_wr,
    input  init_data_in, init_data_addr, init_data_we, init_data_re
  );
endinterface

// File: rtl/dag_host_seq_ctrl.sv
// rtl/dag_host_seq_ctrl.sv - DAG processor job sequencer: load, execute, drain, read back
// Stages run in order LOAD_I, LOAD_D, EXEC/DRAIN, READ; stages with a zero count are skipped.
module dag_host_seq_ctrl #(
  parameter int INSTR_L      = 32,
  parameter int WORD_L       = 32,
  parameter int INSTR_ADDR_L = 10,
  parameter int DATA_ADDR_L  = 12,
  parameter int RD_LAT       = 1,
  parameter int DRAIN_CYCLES = 8,
  parameter int EXEC_TIMEOUT = 65535
) (
  input logic               clk,
  input logic               rst,
  dag_host_seq_ctrl_if.master bus
);

  localparam int CNT_W = ((INSTR_ADDR_L > DATA_ADDR_L) ? INSTR_ADDR_L : DATA_ADDR_L) + 1;
  localparam int CYC_W = $clog2(EXEC_TIMEOUT + DRAIN_CYCLES + RD_LAT + 1);
  localparam int IDX_W = DATA_ADDR_L + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_I, S_LOAD_D, S_EXEC, S_DRAIN,
    S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_FIN
  } state_t;

  state_t                  r_state, w_next;
  logic [INSTR_ADDR_L:0]   r_n_instr;
  logic [DATA_ADDR_L:0]    r_n_data;
  logic [DATA_ADDR_L-1:0]  r_out_base;
  logic [DATA_ADDR_L:0]    r_n_out;
  logic                    r_ping;
  logic [CNT_W-1:0]        r_cnt;
  logic [CYC_W-1:0]        r_cyc;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_err;
  logic                    r_done;
  logic                    r_instr_we;
  logic [INSTR_L-1:0]      r_instr;
  logic [INSTR_ADDR_L-1:0] r_instr_addr;
  logic                    r_data_we;
  logic [WORD_L-1:0]       r_data_in;
  logic [DATA_ADDR_L-1:0]  r_wr_addr;
  logic [WORD_L-1:0]       r_mdata;

  logic                    w_s_ready, w_hs;
  logic                    w_has_i, w_has_d, w_has_o;
  logic                    w_last_i, w_last_d;
  logic                    w_fetch_hit, w_exec_to, w_drain_end, w_rd_ready;
  logic [DATA_ADDR_L-1:0]  w_rd_addr;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic                    w_more;
  logic                    w_counting;

  // First stage after 'cur' whose count is non-zero; EXEC needs instructions.
  function automatic state_t stage_after(input state_t cur, input logic has_i,
                                         input logic has_d, input logic has_o);
    if (cur == S_IDLE && has_i) return S_LOAD_I;
    if ((cur == S_IDLE || cur == S_LOAD_I) && has_d) return S_LOAD_D;
    if ((cur == S_IDLE || cur == S_LOAD_I || cur == S_LOAD_D) && has_i) return S_EXEC;
    if (has_o) return S_RD_ISSUE;
    return S_FIN;
  endfunction

  // In IDLE the decision is made from the live cfg inputs being latched this cycle.
  assign w_has_i = (r_state == S_IDLE) ? (bus.cfg_n_instr != '0) : (r_n_instr != '0);
  assign w_has_d = (r_state == S_IDLE) ? (bus.cfg_n_data  != '0) : (r_n_data  != '0);
  assign w_has_o = (r_state == S_IDLE) ? (bus.cfg_n_out   != '0) : (r_n_out   != '0);

  assign w_s_ready   = (r_state == S_LOAD_I) || (r_state == S_LOAD_D);
  assign w_hs        = bus.s_valid && w_s_ready;
  assign w_last_i    = (r_cnt == (CNT_W'(r_n_instr) - 1'b1));
  assign w_last_d    = (r_cnt == (CNT_W'(r_n_data) - 1'b1));
  assign w_fetch_hit = (bus.current_instr_rd_addr == (r_n_instr[INSTR_ADDR_L-1:0] - 1'b1));
  assign w_exec_to   = (r_cyc == CYC_W'(EXEC_TIMEOUT - 1));
  assign w_drain_end = (r_cyc == CYC_W'(DRAIN_CYCLES - 1));
  assign w_rd_ready  = (r_cyc == CYC_W'(RD_LAT - 1));
  assign w_rd_addr   = r_out_base + r_idx[DATA_ADDR_L-1:0];
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_more      = (w_idx_nxt < r_n_out);
  assign w_counting  = (r_state == S_EXEC) || (r_state == S_DRAIN) || (r_state == S_RD_WAIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.start) w_next = stage_after(S_IDLE, w_has_i, w_has_d, w_has_o);
      S_LOAD_I:   if (w_hs && w_last_i) w_next = stage_after(S_LOAD_I, w_has_i, w_has_d, w_has_o);
      S_LOAD_D:   if (w_hs && w_last_d) w_next = stage_after(S_LOAD_D, w_has_i, w_has_d, w_has_o);
      S_EXEC: begin
        if (w_fetch_hit)    w_next = S_DRAIN;
        else if (w_exec_to) w_next = S_FIN;
      end
      S_DRAIN:    if (w_drain_end) w_next = stage_after(S_DRAIN, w_has_i, w_has_d, w_has_o);
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT:  if (w_rd_ready) w_next = S_RD_OUT;
      S_RD_OUT:   if (bus.m_ready) w_next = w_more ? S_RD_ISSUE : S_FIN;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Cycle counter for EXEC timeout, drain length and read latency; restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_cyc <= '0;
    else if (w_counting && w_next == r_state) r_cyc <= r_cyc + 1'b1;
    else                                      r_cyc <= '0;
  end

  // Config latch, load writes, readback capture and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_instr    <= '0;
      r_n_data     <= '0;
      r_out_base   <= '0;
      r_n_out      <= '0;
      r_ping       <= 1'b0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_instr_we   <= 1'b0;
      r_instr      <= '0;
      r_instr_addr <= '0;
      r_data_we    <= 1'b0;
      r_data_in    <= '0;
      r_wr_addr    <= '0;
      r_mdata      <= '0;
    end else begin
      r_instr_we <= 1'b0;
      r_data_we  <= 1'b0;
      r_done     <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_n_instr  <= bus.cfg_n_instr;
          r_n_data   <= bus.cfg_n_data;
          r_out_base <= bus.cfg_out_base;
          r_n_out    <= bus.cfg_n_out;
          r_ping     <= bus.cfg_ping;
          r_err      <= 1'b0;
          r_cnt      <= '0;
          r_idx      <= '0;
        end
        S_LOAD_I: if (w_hs) begin
          r_instr_we   <= 1'b1;
          r_instr      <= bus.s_data;
          r_instr_addr <= r_cnt[INSTR_ADDR_L-1:0];
          r_cnt        <= w_last_i ? '0 : r_cnt + 1'b1;
        end
        S_LOAD_D: if (w_hs) begin
          r_data_we <= 1'b1;
          r_data_in <= bus.s_data[WORD_L-1:0];
          r_wr_addr <= r_cnt[DATA_ADDR_L-1:0];
          r_cnt     <= w_last_d ? '0 : r_cnt + 1'b1;
        end
        S_EXEC:    if (!w_fetch_hit && w_exec_to) r_err <= 1'b1;
        S_RD_WAIT: if (w_rd_ready) r_mdata <= bus.init_data_out;
        S_RD_OUT:  if (bus.m_ready) r_idx <= w_idx_nxt;
        default: ;
      endcase
    end
  end

  assign bus.s_ready          = w_s_ready;
  assign bus.m_valid          = (r_state == S_RD_OUT);
  assign bus.m_data           = r_mdata;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.done             = r_done;
  assign bus.err_timeout      = r_err;
  assign bus.enable_execution = (r_state == S_EXEC) || (r_state == S_DRAIN);
  assign bus.init_instr       = r_instr;
  assign bus.init_instr_addr  = r_instr_addr;
  assign bus.init_instr_we    = r_instr_we;
  assign bus.io_ping_wr       = r_ping;
  assign bus.init_data_in     = r_data_in;
  assign bus.init_data_addr   = (r_state == S_RD_ISSUE) ? w_rd_addr : r_wr_addr;
  assign bus.init_data_we     = r_data_we;
  assign bus.init_data_re     = (r_state == S_RD_ISSUE);

endmodule

// File: tb/tb_dag_host_seq_ctrl.sv
// tb/tb_dag_host_seq_ctrl.sv - directed self-checking bench for dag_host_seq_ctrl
module tb_dag_host_seq_ctrl;
  localparam int IL = 32, WL = 32, IAL = 10, DAL = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dag_host_seq_ctrl_if #(.INSTR_L(IL), .WORD_L(WL), .INSTR_ADDR_L(IAL), .DATA_ADDR_L(DAL)) bus ();

  dag_host_seq_ctrl #(.INSTR_L(IL), .WORD_L(WL), .INSTR_ADDR_L(IAL), .DATA_ADDR_L(DAL),
                      .RD_LAT(1), .DRAIN_CYCLES(8), .EXEC_TIMEOUT(65535))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // processor model: fetch address walks from 0 while execution is enabled
  logic [IAL-1:0] fa;
  bit fetch_freeze = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) fa <= '0;
    else if (!bus.enable_execution) fa <= '0;
    else if (!fetch_freeze) fa <= fa + 1'b1;
  end
  assign bus.current_instr_rd_addr = fa;

  // data memory model; unwritten words read back as 0xBEEF0000 | addr
  bit [WL-1:0] dmem [0:4095];
  bit          mem_wr [0:4095];
  logic [WL-1:0] rdata = '0;
  always @(posedge clk) begin
    if (bus.init_data_we) begin
      dmem[bus.init_data_addr]   <= bus.init_data_in;
      mem_wr[bus.init_data_addr] <= 1'b1;
    end
    if (bus.init_data_re)
      rdata <= mem_wr[bus.init_data_addr] ? dmem[bus.init_data_addr]
                                          : (32'hBEEF_0000 | 32'(bus.init_data_addr));
  end
  assign bus.init_data_out = rdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitors, sampled on the falling edge
  logic [31:0] iw_addr[$], iw_data[$], dw_addr[$], dw_data[$], ra[$], out_q[$];
  int iw_cyc[$], dw_cyc[$];
  int re_cnt = 0, en_cnt = 0, done_cnt = 0, stab_err = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (bus.init_instr_we) begin
      iw_addr.push_back(32'(bus.init_instr_addr)); iw_data.push_back(bus.init_instr); iw_cyc.push_back(cyc);
    end
    if (bus.init_data_we) begin
      dw_addr.push_back(32'(bus.init_data_addr)); dw_data.push_back(bus.init_data_in); dw_cyc.push_back(cyc);
    end
    if (bus.init_data_re) begin re_cnt++; ra.push_back(32'(bus.init_data_addr)); end
    if (bus.m_valid && bus.m_ready) out_q.push_back(bus.m_data);
    if (bus.enable_execution) en_cnt++;
    if (bus.done) done_cnt++;
    if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stab_err++;
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
  end

  // input stream source, optionally with a bubble every other cycle
  logic [31:0] src [0:15];
  int src_len = 0, src_idx = 0;
  bit bubble = 0, phase = 0, src_hs = 0;
  always @(negedge clk) src_hs = bus.s_valid && bus.s_ready;
  always @(posedge clk) begin
    #1;
    if (rst) src_idx = 0;
    else if (src_hs) src_idx++;
    phase = ~phase;
    bus.s_valid = (src_idx < src_len) && (!bubble || phase);
    bus.s_data  = (src_idx < src_len) ? src[src_idx] : 32'h0;
  end

  // result sink: stalls stall_left cycles on beat stall_beat
  int stall_beat = -1, stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (bus.m_valid && stall_left > 0 && out_q.size() == stall_beat) begin
      bus.m_ready = 1'b0; stall_left--;
    end else bus.m_ready = 1'b1;
  end

  task automatic clr_mon();
    iw_addr.delete(); iw_data.delete(); iw_cyc.delete();
    dw_addr.delete(); dw_data.delete(); dw_cyc.delete();
    ra.delete(); out_q.delete();
    re_cnt = 0; en_cnt = 0; done_cnt = 0; stab_err = 0;
  endtask

  task automatic set_cfg(input int ni, input int nd, input int ob, input int no, input bit ping);
    bus.cfg_n_instr = (IAL+1)'(ni); bus.cfg_n_data = (DAL+1)'(nd);
    bus.cfg_out_base = DAL'(ob); bus.cfg_n_out = (DAL+1)'(no); bus.cfg_ping = ping;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check_eq({tag, "_done"}, bus.done, 1);
    @(negedge clk);
  endtask

  initial begin
    bus.start = 0; bus.s_valid = 0; bus.s_data = '0; bus.m_ready = 1;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_s_ready", bus.s_ready, 0);
    check_eq("rst_m_valid", bus.m_valid, 0);
    check_eq("rst_en", bus.enable_execution, 0);
    check_eq("rst_iwe", bus.init_instr_we, 0);
    check_eq("rst_dwe", bus.init_data_we, 0);
    check_eq("rst_re", bus.init_data_re, 0);
    check_eq("rst_err", bus.err_timeout, 0);
    check_eq("rst_addr", bus.init_data_addr, 0);
    rst = 0;
    @(negedge clk);

    // load-only job: 4 instr, 3 data, no readback
    clr_mon();
    for (int i = 0; i < 4; i++) src[i] = 32'hA0 + i;
    for (int i = 0; i < 3; i++) src[4+i] = 32'hD0 + i;
    src_len = 7; src_idx = 0; bubble = 0;
    set_cfg(4, 3, 0, 0, 1);
    pulse_start();
    wait_done(200, "t1");
    check_eq("t1_n_iw", iw_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t1_iaddr%0d", i), iw_addr[i], i);
      check_eq($sformatf("t1_idata%0d", i), iw_data[i], 32'hA0 + i);
    end
    check_eq("t1_n_dw", dw_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t1_daddr%0d", i), dw_addr[i], i);
      check_eq($sformatf("t1_ddata%0d", i), dw_data[i], 32'hD0 + i);
    end
    check_eq("t1_igap", iw_cyc[3] - iw_cyc[0], 3);
    check_eq("t1_idgap", dw_cyc[0] - iw_cyc[3], 1);
    check_eq("t1_dgap", dw_cyc[2] - dw_cyc[0], 2);
    check_eq("t1_en_cycles", en_cnt, 12);
    check_eq("t1_en_low", bus.enable_execution, 0);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_re", re_cnt, 0);
    check_eq("t1_ping", bus.io_ping_wr, 1);

    // bubbles on input, 5-cycle stall on result beat 1
    clr_mon();
    src[0] = 32'h11; src[1] = 32'h12; src[2] = 32'h21;
    src_len = 3; src_idx = 0; bubble = 1;
    stall_beat = 1; stall_left = 5;
    set_cfg(2, 1, 32'h10, 3, 0);
    pulse_start();
    wait_done(300, "t2");
    bubble = 0;
    check_eq("t2_n_iw", iw_addr.size(), 2);
    check_eq("t2_idata1", iw_data[1], 32'h12);
    check_eq("t2_iaddr1", iw_addr[1], 1);
    check_eq("t2_n_dw", dw_addr.size(), 1);
    check_eq("t2_ddata0", dw_data[0], 32'h21);
    check_eq("t2_re", re_cnt, 3);
    check_eq("t2_n_out", out_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t2_raddr%0d", i), ra[i], 32'h10 + i);
      check_eq($sformatf("t2_out%0d", i), out_q[i], 32'hBEEF_0010 + i);
    end
    check_eq("t2_stall_used", stall_left, 0);
    check_eq("t2_stable", stab_err, 0);
    check_eq("t2_ping", bus.io_ping_wr, 0);

    // readback address wrap
    clr_mon();
    src[0] = 32'h31; src[1] = 32'h77;
    src_len = 2; src_idx = 0;
    set_cfg(1, 1, 12'hFFF, 2, 0);
    pulse_start();
    wait_done(200, "t3");
    check_eq("t3_re", re_cnt, 2);
    check_eq("t3_raddr0", ra[0], 32'hFFF);
    check_eq("t3_raddr1", ra[1], 32'h000);
    check_eq("t3_out0", out_q[0], 32'hBEEF_0FFF);
    check_eq("t3_out1", out_q[1], 32'h77);

    // EXEC timeout, with an ignored start during EXEC
    clr_mon();
    src[0] = 32'h41; src[1] = 32'h42;
    src_len = 2; src_idx = 0; fetch_freeze = 1;
    set_cfg(2, 0, 0, 2, 1);
    pulse_start();
    begin
      int n = 0;
      while (bus.enable_execution !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    end
    check_eq("t4_exec", bus.enable_execution, 1);
    set_cfg(0, 0, 0, 5, 0);
    pulse_start();
    wait_done(70000, "t4");
    fetch_freeze = 0;
    check_eq("t4_err", bus.err_timeout, 1);
    check_eq("t4_en_cycles", en_cnt, 65535);
    check_eq("t4_en_low", bus.enable_execution, 0);
    check_eq("t4_re", re_cnt, 0);
    check_eq("t4_ping", bus.io_ping_wr, 1);
    repeat (4) @(negedge clk);
    check_eq("t4_done_cnt", done_cnt, 1);
    check_eq("t4_err_sticky", bus.err_timeout, 1);

    // zero job: clears the error, done two cycles after start, no enables
    clr_mon();
    set_cfg(0, 0, 0, 0, 0);
    pulse_start();
    check_eq("t6_err_clr", bus.err_timeout, 0);
    @(negedge clk);
    check_eq("t6_busy", bus.busy, 1);
    check_eq("t6_done_early", bus.done, 0);
    @(negedge clk);
    check_eq("t6_done", bus.done, 1);
    check_eq("t6_busy_end", bus.busy, 0);
    @(negedge clk);
    check_eq("t6_no_en", en_cnt + iw_addr.size() + dw_addr.size() + re_cnt, 0);

    // reset during the second data beat, then a clean job
    clr_mon();
    src[0] = 32'h5A; src[1] = 32'h5B;
    for (int i = 0; i < 4; i++) src[2+i] = 32'h60 + i;
    src_len = 6; src_idx = 0;
    set_cfg(2, 4, 0, 0, 0);
    pulse_start();
    begin
      int n = 0;
      while (!(bus.init_data_we === 1'b1 && bus.init_data_addr == 1) && n < 100) begin
        @(negedge clk); n++;
      end
    end
    check_eq("t5_reach", bus.init_data_we, 1);
    #1 rst = 1;
    #1;
    check_eq("t5_async_dwe", bus.init_data_we, 0);
    check_eq("t5_async_addr", bus.init_data_addr, 0);
    check_eq("t5_async_busy", bus.busy, 0);
    check_eq("t5_async_ready", bus.s_ready, 0);
    src_len = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    clr_mon();
    src[0] = 32'h5C; src[1] = 32'h71; src[2] = 32'h72;
    src_len = 3; src_idx = 0;
    set_cfg(1, 2, 1, 1, 0);
    pulse_start();
    wait_done(200, "t5");
    check_eq("t5_iaddr0", iw_addr[0], 0);
    check_eq("t5_idata0", iw_data[0], 32'h5C);
    check_eq("t5_daddr0", dw_addr[0], 0);
    check_eq("t5_daddr1", dw_addr[1], 1);
    check_eq("t5_ddata1", dw_data[1], 32'h72);
    check_eq("t5_re", re_cnt, 1);
    check_eq("t5_out0", out_q[0], 32'h72);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
